// File: rtl/dpram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dpram_fifo_ctrl
// Purpose  : Synchronous FIFO controller for an external dual-port RAM.
//            Port A writes, port B reads. A look-ahead read address hides
//            the RAM's registered read latency, so pops run at full rate.
// Revision : 1.0 - initial release
// ============================================================================
module dpram_fifo_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  // upstream push interface
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  // downstream pop interface
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_ready,
  // status
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              underflow,
  // RAM port A (write)
  output logic              ram_we_a,
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic [DATA_W-1:0] ram_din_a,
  // RAM port B (read only)
  output logic              ram_we_b,
  output logic [DATA_W-1:0] ram_din_b,
  output logic [ADDR_W-1:0] ram_addr_b,
  input  logic [DATA_W-1:0] ram_dout_b
);

  localparam int                CNT_W    = ADDR_W + 1;
  localparam int                DEPTH    = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_rd_valid;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_push;
  logic              w_pop;
  logic [ADDR_W-1:0] w_wr_ptr_inc;
  logic [ADDR_W-1:0] w_rd_ptr_inc;
  logic [CNT_W-1:0]  w_count_after_pop;
  logic [CNT_W-1:0]  w_count_next;

  // Handshakes. Both are masked during reset so the RAM is never written
  // and no pointer moves while the controller is being cleared.
  assign wr_ready = (r_count != FULL_CNT);
  assign w_push   = wr_valid & wr_ready & ~reset;
  assign w_pop    = r_rd_valid & rd_ready & ~reset;

  assign w_wr_ptr_inc = r_wr_ptr + PTR_ONE;
  assign w_rd_ptr_inc = r_rd_ptr + PTR_ONE;

  // Occupancy seen by the read side excludes this cycle's push: that word
  // only lands in the RAM at the end of the cycle and cannot be read yet.
  assign w_count_after_pop = r_count - CNT_W'(w_pop);
  assign w_count_next      = w_count_after_pop + CNT_W'(w_push);

  // RAM pin drive. Reading rd_ptr+1 on a pop puts the next head on
  // ram_dout_b exactly one cycle later, with no bubble.
  assign ram_we_a   = w_push;
  assign ram_addr_a = r_wr_ptr;
  assign ram_din_a  = wr_data;
  assign ram_addr_b = w_pop ? w_rd_ptr_inc : r_rd_ptr;
  assign ram_we_b   = 1'b0;
  assign ram_din_b  = '0;

  assign rd_valid  = r_rd_valid;
  assign rd_data   = ram_dout_b;
  assign level     = r_count;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= w_wr_ptr_inc;
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_ptr_inc;
      end
      r_count <= w_count_next;
    end
  end

  // Head-valid register: data for the head is on ram_dout_b next cycle
  // whenever an already-written entry remains after this cycle's pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= (w_count_after_pop != '0);
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_valid & ~wr_ready) begin
        r_overflow <= 1'b1;
      end
      if (rd_ready & ~r_rd_valid) begin
        r_underflow <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dpram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dpram_fifo_ctrl
// Purpose  : Self-checking bench for dpram_fifo_ctrl with a behavioural
//            16x8 dual-port RAM (registered read, read-old-data on collision).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dpram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_ready;
  logic [4:0] level;
  logic       overflow;
  logic       underflow;
  logic       ram_we_a;
  logic [3:0] ram_addr_a;
  logic [7:0] ram_din_a;
  logic       ram_we_b;
  logic [7:0] ram_din_b;
  logic [3:0] ram_addr_b;
  logic [7:0] ram_dout_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dpram_fifo_ctrl #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_ready   (rd_ready),
    .level      (level),
    .overflow   (overflow),
    .underflow  (underflow),
    .ram_we_a   (ram_we_a),
    .ram_addr_a (ram_addr_a),
    .ram_din_a  (ram_din_a),
    .ram_we_b   (ram_we_b),
    .ram_din_b  (ram_din_b),
    .ram_addr_b (ram_addr_b),
    .ram_dout_b (ram_dout_b)
  );

  // Behavioural dual-port RAM: port A writes, port B registered read.
  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
    if (reset) ram_dout_b <= 8'h00;
    else       ram_dout_b <= mem[ram_addr_b];
  end

  typedef struct {
    logic       rst;
    logic       wv;
    logic [7:0] wd;
    logic       rr;
    logic       e_wr_ready;
    logic       e_rd_valid;
    logic [7:0] e_rd_data;
    logic       chk_data;
    logic [4:0] e_level;
    logic       e_ov;
    logic       e_un;
    logic       chk_ram;
    logic       e_we_a;
    logic [3:0] e_addr_b;
  } vec_t;

  vec_t vecs [20];

  function automatic vec_t mk(logic rst, logic wv, logic [7:0] wd, logic rr,
                              logic er, logic ev, logic [7:0] ed, logic cd,
                              logic [4:0] el, logic eo, logic eu,
                              logic cr, logic ewe, logic [3:0] eab);
    vec_t v;
    v.rst = rst; v.wv = wv; v.wd = wd; v.rr = rr;
    v.e_wr_ready = er; v.e_rd_valid = ev; v.e_rd_data = ed; v.chk_data = cd;
    v.e_level = el; v.e_ov = eo; v.e_un = eu;
    v.chk_ram = cr; v.e_we_a = ewe; v.e_addr_b = eab;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs on the falling edge, then settle before checks.
  task automatic drive(input logic rst, input logic wv, input logic [7:0] wd, input logic rr);
    @(negedge clk);
    reset    = rst;
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; wr_valid = 1'b0; wr_data = 8'h00; rd_ready = 1'b0;

    // Table: single push latency/hold, pop, underflow, mid-run reset.
    //               rst wv wd     rr  wrdy rv data  cd lvl ov un  cr we ab
    vecs[0]  = mk(0, 1, 8'hA5, 0,  1, 0, 8'h00, 0, 0, 0, 0,  1, 1, 0);
    vecs[1]  = mk(0, 0, 8'h00, 0,  1, 0, 8'h00, 0, 1, 0, 0,  1, 0, 0);
    vecs[2]  = mk(0, 0, 8'h00, 0,  1, 1, 8'hA5, 1, 1, 0, 0,  1, 0, 0);
    vecs[3]  = mk(0, 0, 8'h00, 0,  1, 1, 8'hA5, 1, 1, 0, 0,  1, 0, 0);
    vecs[4]  = mk(0, 0, 8'h00, 0,  1, 1, 8'hA5, 1, 1, 0, 0,  1, 0, 0);
    vecs[5]  = mk(0, 0, 8'h00, 0,  1, 1, 8'hA5, 1, 1, 0, 0,  1, 0, 0);
    vecs[6]  = mk(0, 0, 8'h00, 0,  1, 1, 8'hA5, 1, 1, 0, 0,  1, 0, 0);
    vecs[7]  = mk(0, 0, 8'h00, 1,  1, 1, 8'hA5, 1, 1, 0, 0,  1, 0, 1);
    vecs[8]  = mk(0, 0, 8'h00, 0,  1, 0, 8'h00, 0, 0, 0, 0,  1, 0, 1);
    vecs[9]  = mk(0, 0, 8'h00, 1,  1, 0, 8'h00, 0, 0, 0, 0,  1, 0, 1);
    vecs[10] = mk(0, 0, 8'h00, 0,  1, 0, 8'h00, 0, 0, 0, 1,  1, 0, 1);
    vecs[11] = mk(0, 1, 8'h01, 0,  1, 0, 8'h00, 0, 0, 0, 1,  1, 1, 1);
    vecs[12] = mk(0, 1, 8'h02, 0,  1, 0, 8'h00, 0, 1, 0, 1,  1, 1, 1);
    vecs[13] = mk(0, 1, 8'h03, 0,  1, 1, 8'h01, 1, 2, 0, 1,  1, 1, 1);
    vecs[14] = mk(0, 1, 8'h04, 0,  1, 1, 8'h01, 1, 3, 0, 1,  1, 1, 1);
    vecs[15] = mk(0, 1, 8'h05, 0,  1, 1, 8'h01, 1, 4, 0, 1,  1, 1, 1);
    vecs[16] = mk(1, 1, 8'h77, 0,  1, 1, 8'h01, 1, 5, 0, 1,  0, 0, 0);
    vecs[17] = mk(0, 1, 8'h3C, 0,  1, 0, 8'h00, 0, 0, 0, 0,  1, 1, 0);
    vecs[18] = mk(0, 0, 8'h00, 0,  1, 0, 8'h00, 0, 1, 0, 0,  1, 0, 0);
    vecs[19] = mk(0, 0, 8'h00, 0,  1, 1, 8'h3C, 1, 1, 0, 0,  1, 0, 0);

    drive(1, 0, 8'h00, 0);
    drive(1, 0, 8'h00, 0);

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].rst, vecs[i].wv, vecs[i].wd, vecs[i].rr);
      check($sformatf("v%0d_wr_ready", i), 32'(wr_ready), 32'(vecs[i].e_wr_ready));
      check($sformatf("v%0d_rd_valid", i), 32'(rd_valid), 32'(vecs[i].e_rd_valid));
      check($sformatf("v%0d_level", i), 32'(level), 32'(vecs[i].e_level));
      check($sformatf("v%0d_overflow", i), 32'(overflow), 32'(vecs[i].e_ov));
      check($sformatf("v%0d_underflow", i), 32'(underflow), 32'(vecs[i].e_un));
      if (vecs[i].chk_data)
        check($sformatf("v%0d_rd_data", i), 32'(rd_data), 32'(vecs[i].e_rd_data));
      if (vecs[i].chk_ram) begin
        check($sformatf("v%0d_we_a", i), 32'(ram_we_a), 32'(vecs[i].e_we_a));
        check($sformatf("v%0d_addr_b", i), 32'(ram_addr_b), 32'(vecs[i].e_addr_b));
        check($sformatf("v%0d_we_b", i), 32'({ram_we_b, ram_din_b}), 32'd0);
      end
    end

    // Fill to full, then attempt one push too many.
    drive(1, 0, 8'h00, 0);
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 8'(i), 0);
      check("fill_wr_ready", 32'(wr_ready), 32'd1);
      check("fill_addr_a", 32'(ram_addr_a), 32'(i));
    end
    drive(0, 1, 8'hEE, 0);
    check("full_wr_ready", 32'(wr_ready), 32'd0);
    check("full_level", 32'(level), 32'd16);
    check("full_we_a", 32'(ram_we_a), 32'd0);
    check("full_overflow_pre", 32'(overflow), 32'd0);
    drive(0, 0, 8'h00, 0);
    check("overflow_set", 32'(overflow), 32'd1);
    check("overflow_level", 32'(level), 32'd16);

    // Drain from full with rd_ready held high: one word per cycle.
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 8'h00, 1);
      check("drain_valid", 32'(rd_valid), 32'd1);
      check("drain_data", 32'(rd_data), 32'(i));
      if (i == 0) check("drain_wr_ready_same", 32'(wr_ready), 32'd0);
      if (i == 1) check("drain_wr_ready_next", 32'(wr_ready), 32'd1);
    end
    drive(0, 0, 8'h00, 0);
    check("drained_valid", 32'(rd_valid), 32'd0);
    check("drained_level", 32'(level), 32'd0);

    // Streaming: 40 words through with simultaneous push and pop.
    begin
      int sent = 0;
      int got  = 0;
      for (int c = 0; c < 200 && got < 40; c++) begin
        drive(0, sent < 40, 8'(8'h10 + sent), 1);
        if (c == 20) check("stream_level", 32'(level), 32'd2);
        if (rd_valid) begin
          check("stream_data", 32'(rd_data), 32'(8'(8'h10 + got)));
          got++;
        end
        if (sent < 40 && wr_ready) sent++;
      end
      check("stream_count", 32'(got), 32'd40);
    end
    drive(0, 0, 8'h00, 0);
    check("stream_end_level", 32'(level), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
